// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a saturating-count debounce FSM.
// Produces a clean level plus one-cycle rise/fall events.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic raw_in,
    input  logic enable,
    output logic clean_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             clean_next;
    logic             rise_next;
    logic             fall_next;
    logic             s1;
    logic             s2;

    // The synchronizer runs regardless of enable so the FSM always sees fresh data.
    always_ff @(posedge clock) begin
        if (clear) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= LOW;
            count     <= '0;
            clean_out <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            clean_out <= clean_next;
            rise      <= rise_next;
            fall      <= fall_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        clean_next = clean_out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (enable) begin
            unique case (state)
                LOW: begin
                    if (s2) begin
                        state_next = WAIT_HIGH;
                        count_next = ONE_COUNT;
                    end else begin
                        count_next = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state_next = LOW;
                        count_next = '0;
                    end else if (count == LAST_COUNT) begin
                        state_next = HIGH;
                        count_next = '0;
                        clean_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        count_next = count + ONE_COUNT;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state_next = WAIT_LOW;
                        count_next = ONE_COUNT;
                    end else begin
                        count_next = '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state_next = HIGH;
                        count_next = '0;
                    end else if (count == LAST_COUNT) begin
                        state_next = LOW;
                        count_next = '0;
                        clean_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        count_next = count + ONE_COUNT;
                    end
                end
                default: begin
                    state_next = LOW;
                    count_next = '0;
                end
            endcase
        end
    end

    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed timing scenarios plus a
// randomized run compared against a run-length reference model.
module tb_input_debouncer;

    localparam int STABLE = 4;

    logic clock;
    logic clear;
    logic raw_in;
    logic enable;
    logic clean_out;
    logic rise;
    logic fall;
    logic busy;

    int n_checks;
    int n_fail;

    // Reference model: a new level is accepted after STABLE consecutive
    // enabled synchronized samples that differ from the current clean level.
    logic [1:0] m_sync;
    logic       m_clean;
    logic       m_rise;
    logic       m_fall;
    int         m_run;

    input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .raw_in   (raw_in),
        .enable   (enable),
        .clean_out(clean_out),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] dut_vec();
        return {clean_out, rise, fall, busy};
    endfunction

    function automatic logic [3:0] model_vec();
        return {m_clean, m_rise, m_fall, (m_run != 0)};
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic c);
        logic sample;
        if (c) begin
            m_sync  = 2'b00;
            m_clean = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
        end else begin
            sample = m_sync[1];
            m_sync = {m_sync[0], r};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (e) begin
                if (sample != m_clean) begin
                    m_run = m_run + 1;
                    if (m_run == STABLE) begin
                        m_clean = sample;
                        m_rise  = sample;
                        m_fall  = !sample;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    // Drive inputs at the falling edge, advance one rising edge, sample 1ns later.
    task automatic tick(input logic r, input logic e, input logic c);
        @(negedge clock);
        raw_in = r;
        enable = e;
        clear  = c;
        @(posedge clock);
        model_edge(r, e, c);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec() !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset: got %b expected 0000", dut_vec());
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL clean_rise edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] exp;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            exp = {(k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL clean_fall edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick((k < 2), 1'b1, 1'b0);
            exp = {1'b0, 1'b0, 1'b0, (k == 2 || k == 3)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL glitch edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL glitch_then_rise edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_clear_mid();
        logic [3:0] exp;
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec() !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL clear_mid: got %b expected 0000", dut_vec());
        end
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL clear_release edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [3:0] exp;
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (dut_vec() !== 4'b0001) begin
                n_fail++;
                $display("[TB] FAIL enable_freeze cycle %0d: got %b expected 0001", k, dut_vec());
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            exp = {(k >= 1), (k == 1), 1'b0, (k == 0)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL enable_resume edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_sync_clear();
        logic [3:0] exp;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (k == 2 || k == 3) begin
                #1 clear = 1'b1;
                #2 clear = 1'b0;
            end
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("[TB] FAIL sync_clear edge %0d: got %b expected %b", k, dut_vec(), exp);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        logic e;
        logic c;
        int   hold;
        r    = 1'b0;
        hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                r    = ~r;
                hold = $urandom_range(1, 8);
            end
            hold--;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            tick(r, e, c);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", k, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_sync   = 2'b00;
        m_clean  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_run    = 0;
        clear    = 1'b1;
        raw_in   = 1'b0;
        enable   = 1'b1;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_clear_mid();
        test_enable_freeze();
        test_sync_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
